// File: rtl/signed_bcd_addsub_seq.sv
// Digit-serial signed (sign-magnitude) BCD adder/subtractor, LSD first.
// Picks the larger magnitude in one compare cycle, then processes one digit per clock.
module signed_bcd_addsub_seq #(
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op,
  input  logic              a_sign,
  input  logic [4*NDIG-1:0] a_mag,
  input  logic              b_sign,
  input  logic [4*NDIG-1:0] b_mag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              r_sign,
  output logic [4*NDIG-1:0] r_mag,
  output logic              ovf,
  output logic              err,
  output logic              busy
);

  localparam int W  = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, CMP, CALC, DONE} state_t;

  state_t          state;
  logic            a_sign_q;
  logic            b_sign_q;
  logic            op_q;
  logic [W-1:0]    a_mag_q;
  logic [W-1:0]    b_mag_q;
  logic [W-1:0]    x_q;
  logic [W-1:0]    y_q;
  logic            sub_q;
  logic            res_sign_q;
  logic            cy_q;
  logic [CW-1:0]   cnt;

  logic            eff_b_sign;
  logic            same;
  logic            a_lt_b;
  logic            bad;
  logic            swap;
  logic [4:0]      dig_res;
  logic [W-1:0]    mag_next;

  // {carry, digit} of one BCD digit addition
  function automatic logic [4:0] add_digit(input logic [3:0] x, input logic [3:0] y,
                                           input logic c);
    logic [4:0] s;
    logic [4:0] t;
    s = {1'b0, x} + {1'b0, y} + {4'b0, c};
    t = s - 5'd10;
    if (s > 5'd9) add_digit = {1'b1, t[3:0]};
    else          add_digit = {1'b0, s[3:0]};
  endfunction

  // {borrow, digit} of one BCD digit subtraction
  function automatic logic [4:0] sub_digit(input logic [3:0] x, input logic [3:0] y,
                                           input logic b);
    logic signed [5:0] s;
    logic signed [5:0] t;
    s = $signed({2'b00, x}) - $signed({2'b00, y}) - $signed({5'b0, b});
    t = s + 6'sd10;
    if (s < 6'sd0) sub_digit = {1'b1, t[3:0]};
    else           sub_digit = {1'b0, s[3:0]};
  endfunction

  // MSD-first less/equal/greater cascade; returns 1 when |a| < |b|
  function automatic logic mag_lt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic lt;
    logic eq;
    lt = 1'b0;
    eq = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (eq) begin
        if (a[4*i +: 4] < b[4*i +: 4]) begin
          lt = 1'b1;
          eq = 1'b0;
        end else if (a[4*i +: 4] > b[4*i +: 4]) begin
          eq = 1'b0;
        end
      end
    end
    mag_lt = lt;
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] m);
    logic bad_any;
    bad_any = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (m[4*i +: 4] > 4'd9) bad_any = 1'b1;
    end
    has_bad_digit = bad_any;
  endfunction

  always_comb begin
    eff_b_sign = b_sign_q ^ op_q;
    same       = (a_sign_q == eff_b_sign);
    a_lt_b     = mag_lt(a_mag_q, b_mag_q);
    bad        = has_bad_digit(a_mag_q) | has_bad_digit(b_mag_q);
    swap       = !same && a_lt_b;
  end

  always_comb begin
    dig_res  = sub_q ? sub_digit(x_q[3:0], y_q[3:0], cy_q)
                     : add_digit(x_q[3:0], y_q[3:0], cy_q);
    mag_next = r_mag;
    mag_next[4*cnt +: 4] = dig_res[3:0];
  end

  // Operand capture and digit shifters carry no reset; control below qualifies them.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid && in_ready) begin
      a_sign_q <= a_sign;
      b_sign_q <= b_sign;
      op_q     <= op;
      a_mag_q  <= a_mag;
      b_mag_q  <= b_mag;
    end
    if (state == CMP) begin
      x_q <= swap ? b_mag_q : a_mag_q;
      y_q <= swap ? a_mag_q : b_mag_q;
    end else if (state == CALC) begin
      x_q <= x_q >> 4;
      y_q <= y_q >> 4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      r_sign     <= 1'b0;
      r_mag      <= '0;
      ovf        <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
      cy_q       <= 1'b0;
      sub_q      <= 1'b0;
      res_sign_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= CMP;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CMP: begin
          cnt    <= '0;
          cy_q   <= 1'b0;
          r_mag  <= '0;
          r_sign <= 1'b0;
          ovf    <= 1'b0;
          if (bad) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            err        <= 1'b0;
            sub_q      <= !same;
            res_sign_q <= swap ? eff_b_sign : a_sign_q;
            state      <= CALC;
          end
        end
        CALC: begin
          r_mag <= mag_next;
          cy_q  <= dig_res[4];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NDIG - 1)) begin
            state  <= DONE;
            ovf    <= !sub_q && dig_res[4];
            // A zero magnitude is always reported positive
            r_sign <= (mag_next == '0) ? 1'b0 : res_sign_q;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_bcd_addsub_seq.sv
// Directed bench for signed_bcd_addsub_seq at NDIG=3: vector table plus handshake/reset sequences.
module tb_signed_bcd_addsub_seq;
  localparam int NDIG = 3;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op = 1'b0;
  logic         a_sign = 1'b0;
  logic [W-1:0] a_mag = '0;
  logic         b_sign = 1'b0;
  logic [W-1:0] b_mag = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         r_sign;
  logic [W-1:0] r_mag;
  logic         ovf;
  logic         err;
  logic         busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         op;
    logic         as;
    logic [W-1:0] am;
    logic         bs;
    logic [W-1:0] bm;
    logic         e_sign;
    logic [W-1:0] e_mag;
    logic         e_ovf;
    logic         e_err;
    int           e_lat;
  } vec_t;

  vec_t vecs[12];

  signed_bcd_addsub_seq #(.NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a_sign(a_sign), .a_mag(a_mag), .b_sign(b_sign), .b_mag(b_mag),
    .out_valid(out_valid), .out_ready(out_ready), .r_sign(r_sign), .r_mag(r_mag),
    .ovf(ovf), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic rdy);
    @(negedge clk);
    op        = v.op;
    a_sign    = v.as;
    a_mag     = v.am;
    b_sign    = v.bs;
    b_mag     = v.bm;
    out_ready = rdy;
    in_valid  = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    drive(v, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d_busy", idx), {31'b0, busy}, 32'd1);
    wait_valid(lat);
    chk($sformatf("v%0d_latency", idx), lat, v.e_lat);
    chk($sformatf("v%0d_sign", idx), {31'b0, r_sign}, {31'b0, v.e_sign});
    chk($sformatf("v%0d_mag", idx), {20'b0, r_mag}, {20'b0, v.e_mag});
    chk($sformatf("v%0d_ovf", idx), {31'b0, ovf}, {31'b0, v.e_ovf});
    chk($sformatf("v%0d_err", idx), {31'b0, err}, {31'b0, v.e_err});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_pulse", idx), {31'b0, out_valid}, 32'd0);
    chk($sformatf("v%0d_ready_back", idx), {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t hv;
    // op, a_sign, a_mag, b_sign, b_mag, exp sign, exp mag, exp ovf, exp err, latency
    vecs[0]  = '{1'b0, 1'b0, 12'h123, 1'b0, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0, 5};
    vecs[1]  = '{1'b0, 1'b0, 12'h999, 1'b0, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0, 5};
    vecs[2]  = '{1'b1, 1'b0, 12'h123, 1'b0, 12'h456, 1'b1, 12'h333, 1'b0, 1'b0, 5};
    vecs[3]  = '{1'b1, 1'b1, 12'h700, 1'b1, 12'h200, 1'b1, 12'h500, 1'b0, 1'b0, 5};
    vecs[4]  = '{1'b0, 1'b1, 12'h250, 1'b0, 12'h250, 1'b0, 12'h000, 1'b0, 1'b0, 5};
    vecs[5]  = '{1'b1, 1'b1, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 5};
    vecs[6]  = '{1'b1, 1'b0, 12'h100, 1'b0, 12'h001, 1'b0, 12'h099, 1'b0, 1'b0, 5};
    vecs[7]  = '{1'b0, 1'b0, 12'h1A3, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1, 2};
    vecs[8]  = '{1'b0, 1'b0, 12'h045, 1'b1, 12'h012, 1'b0, 12'h033, 1'b0, 1'b0, 5};
    vecs[9]  = '{1'b0, 1'b1, 12'h500, 1'b1, 12'h600, 1'b1, 12'h100, 1'b1, 1'b0, 5};
    vecs[10] = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h005, 1'b1, 12'h005, 1'b0, 1'b0, 5};
    vecs[11] = '{1'b1, 1'b1, 12'h321, 1'b0, 12'h00F, 1'b0, 12'h000, 1'b0, 1'b1, 2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_r", {19'b0, r_sign, r_mag}, 32'd0);
    chk("rst_flags", {30'b0, ovf, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Result held with out_ready low; busy-time requests must be dropped
    hv = '{1'b0, 1'b0, 12'h111, 1'b0, 12'h222, 1'b0, 12'h333, 1'b0, 1'b0, 5};
    drive(hv, 1'b0);
    @(posedge clk);
    #1;
    a_mag = 12'h888;
    b_mag = 12'h777;
    begin
      int lat;
      wait_valid(lat);
      chk("hold_latency", lat, 5);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_mag", k), {20'b0, r_mag}, 32'h333);
      chk($sformatf("hold%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_valid", {31'b0, out_valid}, 32'd0);
    chk("hold_release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("no_stored_request", {31'b0, busy}, 32'd0);
    chk("idle_mag_held", {20'b0, r_mag}, 32'h333);

    // Reset during CALC aborts immediately with no result
    drive(vecs[0], 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_calc_busy", {31'b0, busy}, 32'd1);
    chk("mid_calc_digit0", {20'b0, r_mag}, 32'h009);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_mag", {20'b0, r_mag}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_output", {31'b0, out_valid}, 32'd0);
    chk("abort_idle", {31'b0, in_ready}, 32'd1);
    run_vec(vecs[2], 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
